// File: rtl/seq_ctrl.sv
// seq_ctrl: sequencer for the regfile/ALU/RAM series computation.
// Optional freeze input enabled by defining SEQ_CTRL_HOLD_EN.
module seq_ctrl #(
  parameter int ADDR_W    = 6,
  parameter int START_IDX = 2,
  parameter int LAST_IDX  = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              src,
  output logic              wer,
  output logic              wea,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [ADDR_W-1:0] addr3,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    RD_ADDR,
    RD_WB,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(START_IDX);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_IDX);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO   = ADDR_W'(2);

  if (START_IDX < 2) begin : g_bad_start
    $error("seq_ctrl: START_IDX must be >= 2");
  end
  if (LAST_IDX < START_IDX || LAST_IDX > (1 << ADDR_W) - 1) begin : g_bad_last
    $error("seq_ctrl: LAST_IDX out of range");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              is_last;
  logic              st_calc, st_rda, st_rwb, st_done;
  logic              frz;

  assign is_last = (idx_q == LAST);
  assign st_calc = (state_q == CALC);
  assign st_rda  = (state_q == RD_ADDR);
  assign st_rwb  = (state_q == RD_WB);
  assign st_done = (state_q == DONE);

`ifdef SEQ_CTRL_HOLD_EN
  // Freeze only inside the working states; IDLE and DONE ignore hold.
  assign frz = hold & (st_calc | st_rda | st_rwb);
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign frz = 1'b0;
`endif

  // State and index registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and index sequencing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!frz) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            idx_d   = FIRST;
            state_d = CALC;
          end
        end
        CALC: begin
          if (is_last) begin
            idx_d   = FIRST;
            state_d = RD_ADDR;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
        RD_ADDR: begin
          state_d = RD_WB;
        end
        RD_WB: begin
          if (is_last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ONE;
            state_d = RD_ADDR;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Moore output decode; enables drop while frozen.
  always_comb begin
    src   = 1'b0;
    wer   = 1'b0;
    wea   = 1'b0;
    addr1 = '0;
    addr2 = '0;
    addr3 = '0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (1'b1)
      st_calc: begin
        addr1 = idx_q - TWO;
        addr2 = idx_q - ONE;
        addr3 = idx_q;
        wer   = ~frz;
        wea   = ~frz;
        busy  = 1'b1;
      end
      st_rda: begin
        addr3 = idx_q;
        src   = 1'b1;
        busy  = 1'b1;
      end
      st_rwb: begin
        addr3 = idx_q;
        src   = 1'b1;
        wer   = ~frz;
        busy  = 1'b1;
      end
      st_done: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed bench for seq_ctrl with a cycle trace scoreboard.
// Includes a small regfile/ALU/RAM model to check computed data.
module tb_seq_ctrl;

`ifdef SEQ_CTRL_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, hold, load;
  logic       src, wer, wea, busy, done;
  logic [5:0] addr1, addr2, addr3;

  always #5 clk = ~clk;

  seq_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .hold (hold),
    .src  (src),
    .wer  (wer),
    .wea  (wea),
    .addr1(addr1),
    .addr2(addr2),
    .addr3(addr3),
    .busy (busy),
    .done (done)
  );

  logic [31:0] rf [64];
  logic [31:0] ram[64];
  logic [31:0] doutb, alu;
  logic [31:0] fib[64];

  assign alu = rf[addr1] + rf[addr2];

  always @(posedge clk) begin
    if (load) begin
      rf[0] <= 32'd1;
      rf[1] <= 32'd1;
    end else if (wer) begin
      rf[addr3] <= src ? doutb : alu;
    end
    if (wea) ram[addr3] <= alu;
    doutb <= ram[addr3];
  end

  typedef struct packed {
    logic       src;
    logic       wer;
    logic       wea;
    logic [5:0] a1;
    logic [5:0] a2;
    logic [5:0] a3;
    logic       busy;
    logic       done;
  } out_t;

  out_t q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_run(input bit with_hold);
    q.push_back('0);
    for (int i = 2; i <= 63; i++) begin
      if (with_hold && HOLD_EN && i == 7)
        repeat (5)
          q.push_back({1'b0, 1'b0, 1'b0, 6'(i - 2), 6'(i - 1), 6'(i),
                       1'b1, 1'b0});
      q.push_back({1'b0, 1'b1, 1'b1, 6'(i - 2), 6'(i - 1), 6'(i),
                   1'b1, 1'b0});
    end
    for (int i = 2; i <= 63; i++) begin
      q.push_back({1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'(i), 1'b1, 1'b0});
      q.push_back({1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 6'(i), 1'b1, 1'b0});
    end
    q.push_back({1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1});
  endtask

  task automatic cyc(input logic s, input logic h, input logic r,
                     input string tag);
    out_t obs, exp;
    @(posedge clk);
    #1;
    start = s;
    hold  = h;
    rst   = r;
    @(negedge clk);
    obs = {src, wer, wea, addr1, addr2, addr3, busy, done};
    exp = (q.size() > 0) ? q.pop_front() : out_t'('0);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drain(input int start_n, input int start_from,
                       input int hold_lo, input int hold_hi,
                       input int rst_at, input int exp_done,
                       input string tag);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (q.size() > 0 && n < 400) begin
      n++;
      if (n == rst_at) begin
        out_t f;
        f = q[0];
        q.delete();
        q.push_back(f);
        q.push_back('0);
      end
      cyc(n == start_n || (start_from > 0 && n >= start_from),
          n >= hold_lo && n <= hold_hi, n == rst_at, tag);
      if (done && !seen) begin
        seen = 1'b1;
        chk({tag, "_done_cycle"}, n, exp_done);
      end
    end
    checks++;
    assert (q.size() == 0) else begin
      fails++;
      $error("FAIL %s_timeout obs=%0d exp=0", tag, q.size());
    end
    if (exp_done > 0 && !seen) begin
      checks++;
      fails++;
      $error("FAIL %s_no_done obs=0 exp=1", tag);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    hold  = 1'b0;
    load  = 1'b1;
    fib[0] = 32'd1;
    fib[1] = 32'd1;
    for (int i = 2; i < 64; i++) fib[i] = fib[i - 1] + fib[i - 2];

    cyc(1'b1, 1'b0, 1'b1, "reset0");
    cyc(1'b1, 1'b0, 1'b1, "reset1");
    load = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, "idle");

    push_run(1'b0);
    cyc(1'b1, 1'b0, 1'b0, "start1");
    drain(0, 0, 0, -1, 0, 187, "run1");
    chk("rf2", rf[2], 32'd2);
    chk("rf10", rf[10], 32'd89);
    chk("ram10", ram[10], 32'd89);
    chk("rf63", rf[63], fib[63]);
    chk("ram40", ram[40], fib[40]);

    push_run(1'b0);
    cyc(1'b1, 1'b0, 1'b0, "start2");
    drain(19, 185, 0, -1, 0, 187, "run2_busy_start");

    push_run(1'b0);
    cyc(1'b1, 1'b0, 1'b0, "start3");
    drain(0, 0, 0, -1, 120, 0, "run3_rst");
    cyc(1'b0, 1'b0, 1'b0, "post_rst_idle");

    push_run(1'b0);
    cyc(1'b1, 1'b0, 1'b0, "start4");
    drain(0, 0, 0, -1, 0, 187, "run4_rerun");
    chk("rf10_rerun", rf[10], 32'd89);

    push_run(1'b1);
    cyc(1'b1, 1'b0, 1'b0, "start5");
    drain(0, 0, 6, 10, 0, HOLD_EN ? 192 : 187, "run5_hold");
    chk("rf63_hold", rf[63], fib[63]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
